run_controller: RTL and testbench
=================================

// Module: run_controller
// PURPOSE
//  Debug/run sequencer that sits between the board and the CPU instruction controller.
//  It gates the two-phase fetch/execute sequencer through cpu_en and supports RUN, HALT and
//  single STEP, one PC breakpoint, detection of the STOP opcode, and a retired-instruction counter.
//  Commands arrive over a valid/ready port driven by the front-panel or UART command decoder.
// PARAMETERS
//  CNT_W      16      width of instr_count (saturating)
//  STOP_OP    4'hF    opcode that latches the STOPPED state
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  CLR          in   1      synchronous active-high reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      command accepted when cmd_valid&&cmd_ready
//  cmd          in   3      1=RUN 2=HALT 3=STEP 4=SETBP 5=CLRBP 6=CLRCNT; 0,7=NOP
//  cmd_data     in   8      breakpoint address for SETBP
//  pc           in   8      current CPU program counter
//  fetch        in   1      1 = CPU sequencer is in fetch phase (state 0), 0 = execute phase
//  opcode       in   4      opcode currently in IR (valid in execute phase)
//  cpu_en       out  1      clock enable to CPU sequencer/PC/regs (combinational, see below)
//  halted       out  1      1 in HALT state
//  bp_hit       out  1      sticky: last halt was caused by the breakpoint
//  stopped      out  1      1 in STOP state
//  instr_count  out  CNT_W  retired instructions
// BEHAVIOUR
//  Reset (CLR=1 at posedge): state=HALT, bp_en=0, bp_addr=0, bp_skip=0, bp_hit=0,
//   instr_count=0; hence cpu_en=0, halted=1, stopped=0, cmd_ready=1.
//  States: HALT, RUN, STEP, DRAIN, STOP (registered).
//  retire = cpu_en && !fetch (the enabled execute cycle ends one instruction).
//  bp_match = bp_en && fetch && pc==bp_addr && !bp_skip.
//  cpu_en = (RUN && !bp_match) || STEP || DRAIN; 0 in HALT/STOP. No register stage.
//  cmd_ready = 1 in HALT, RUN, STOP; 0 in STEP and DRAIN (cmd is held by the sender).
//  HALT: RUN cmd -> RUN, bp_hit<=0, bp_skip<=1. STEP cmd -> STEP, bp_hit<=0.
//  RUN:  retire && opcode==STOP_OP -> STOP (highest priority);
//        else bp_match -> HALT, bp_hit<=1 (the CPU is frozen before fetching bp_addr);
//        else HALT cmd -> DRAIN if !fetch is false (mid-instruction), or HALT if the same
//        cycle retires; RUN cmd is a NOP.
//  STEP: exactly one retire, then -> HALT (-> STOP if that opcode==STOP_OP).
//        The breakpoint is ignored in STEP. A STEP issued while the CPU is in execute
//        phase retires that instruction only.
//  DRAIN: cpu_en=1 until retire, then -> HALT (or STOP on the STOP opcode).
//  STOP: cpu_en=0 and stopped=1; RUN/STEP ignored; only CLR leaves STOP.
//        SETBP/CLRBP/CLRCNT still act.
//  bp_skip: set on the RUN cmd, cleared at the first retire after it, so resuming on a
//   breakpoint executes that instruction once.
//  SETBP: bp_addr<=cmd_data, bp_en<=1. CLRBP: bp_en<=0. Both accepted in any ready state.
//  instr_count: +1 on retire, saturates at all-ones (no wrap). CLRCNT with a simultaneous
//   retire -> 0 (clear wins).
//  CLR in any state, including mid-instruction, returns all state to reset values on the
//   next edge. The CPU sequencer is reset by its own clear.
// TESTING
//  1 CLR, then RUN with a program of 3 ADDs and STOP -> cpu_en high; instr_count=4 and
//    stopped=1 after 8 enabled cycles; RUN ignored in STOP.
//  2 From HALT, STEP x3 -> cmd_ready low for 2 cycles each; instr_count=1,2,3;
//    halted=1 between steps.
//  3 SETBP 8'h05, RUN -> halted with fetch=1, pc=05, bp_hit=1; a second RUN executes
//    pc 05 and continues.
//  4 HALT cmd while the CPU is in fetch phase -> DRAIN 1 cycle, cmd_ready=0, then HALT
//    with fetch=1.
//  5 instr_count preloaded near all-ones via long run (CNT_W=4) -> saturates at 4'hF;
//    CLRCNT on a retire cycle -> 0.
//  6 CLR asserted in STEP and in DRAIN -> next cycle halted=1, cpu_en=0, bp_en=0, count=0.

Source files
------------

// File: rtl/run_controller_if.sv
// Command port of the run controller: opcode plus 8-bit argument under a valid/ready handshake.
interface run_controller_if;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [2:0] cmd_dat;
  logic [7:0] arg_dat;

  modport master (output cmd_vld, cmd_dat, arg_dat, input cmd_rdy);
  modport slave  (input cmd_vld, cmd_dat, arg_dat, output cmd_rdy);
endinterface

// File: rtl/run_controller.sv
// Run/halt/step sequencer gating the CPU fetch/execute enable, with one PC breakpoint, STOP detect and retire counter.
// cpu_en is combinational (no register stage); commands are back-pressured while a STEP or DRAIN finishes its instruction.
module run_controller #(
  parameter int         CNT_W   = 16,
  parameter logic [3:0] STOP_OP = 4'hF
) (
  input  logic             clk_i,
  input  logic             clr_i,
  run_controller_if.slave  cmd_if,
  input  logic [7:0]       pc_i,
  input  logic             fetch_i,
  input  logic [3:0]       opcode_i,
  output logic             cpu_en_o,
  output logic             halted_o,
  output logic             bp_hit_o,
  output logic             stopped_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_DRAIN, S_STOP} state_e;

  localparam logic [2:0] CMD_RUN    = 3'd1;
  localparam logic [2:0] CMD_HALT   = 3'd2;
  localparam logic [2:0] CMD_STEP   = 3'd3;
  localparam logic [2:0] CMD_SETBP  = 3'd4;
  localparam logic [2:0] CMD_CLRBP  = 3'd5;
  localparam logic [2:0] CMD_CLRCNT = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             bp_en_q, bp_en_d;
  logic [7:0]       bp_addr_q, bp_addr_d;
  logic             bp_skip_q, bp_skip_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic cmd_fire;
  logic bp_match;
  logic retire;
  logic stop_hit;
  logic run_cmd;
  logic step_cmd;

  assign cmd_fire = cmd_if.cmd_vld && cmd_if.cmd_rdy;
  assign run_cmd  = cmd_fire && (cmd_if.cmd_dat == CMD_RUN);
  assign step_cmd = cmd_fire && (cmd_if.cmd_dat == CMD_STEP);
  assign bp_match = bp_en_q && fetch_i && (pc_i == bp_addr_q) && !bp_skip_q;
  assign retire   = cpu_en_o && !fetch_i;
  assign stop_hit = retire && (opcode_i == STOP_OP);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= S_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: begin
        if (run_cmd)       state_d = S_RUN;
        else if (step_cmd) state_d = S_STEP;
      end
      S_RUN: begin
        if (stop_hit)      state_d = S_STOP;
        else if (bp_match) state_d = S_HALT;
        // A halt request that lands on a retire cycle has nothing left to drain.
        else if (cmd_fire && cmd_if.cmd_dat == CMD_HALT)
          state_d = retire ? S_HALT : S_DRAIN;
      end
      S_STEP, S_DRAIN: begin
        if (retire) state_d = stop_hit ? S_STOP : S_HALT;
      end
      S_STOP:  state_d = S_STOP;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    cpu_en_o       = 1'b0;
    cmd_if.cmd_rdy = 1'b1;
    halted_o       = 1'b0;
    stopped_o      = 1'b0;
    case (state_q)
      S_HALT:  halted_o = 1'b1;
      S_RUN:   cpu_en_o = !bp_match;
      S_STEP, S_DRAIN: begin
        cpu_en_o       = 1'b1;
        cmd_if.cmd_rdy = 1'b0;
      end
      S_STOP:  stopped_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    bp_skip_d = bp_skip_q;
    bp_hit_d  = bp_hit_q;
    count_d   = count_q;
    if (retire) bp_skip_d = 1'b0;
    if (retire && count_q != CNT_MAX) count_d = count_q + CNT_ONE;
    if (cmd_fire) begin
      case (cmd_if.cmd_dat)
        CMD_SETBP: begin
          bp_addr_d = cmd_if.arg_dat;
          bp_en_d   = 1'b1;
        end
        CMD_CLRBP:  bp_en_d = 1'b0;
        CMD_CLRCNT: count_d = '0;
        default: ;
      endcase
    end
    // Resuming from a breakpoint must execute the instruction at bp_addr once.
    if (state_q == S_HALT && run_cmd) begin
      bp_hit_d  = 1'b0;
      bp_skip_d = 1'b1;
    end
    if (state_q == S_HALT && step_cmd) bp_hit_d = 1'b0;
    if (state_q == S_RUN && !stop_hit && bp_match) bp_hit_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      bp_en_q   <= 1'b0;
      bp_addr_q <= 8'h00;
      bp_skip_q <= 1'b0;
      bp_hit_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      bp_skip_q <= bp_skip_d;
      bp_hit_q  <= bp_hit_d;
      count_q   <= count_d;
    end
  end

  assign bp_hit_o      = bp_hit_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a two-phase CPU stand-in, a flag-based reference model checked every cycle, and directed scenarios.
module tb_run_controller;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  localparam logic [2:0] C_RUN = 3'd1, C_HALT = 3'd2, C_STEP = 3'd3;
  localparam logic [2:0] C_SETBP = 3'd4, C_CLRBP = 3'd5, C_CLRCNT = 3'd6;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic [7:0]       pc = 8'h00;
  logic             fetch = 1'b1;
  logic [3:0]       ir = 4'h0;
  logic             cpu_en, halted, bp_hit, stopped;
  logic [CNT_W-1:0] count;
  logic [3:0]       prog [256];

  int checks = 0;
  int errors = 0;

  run_controller_if cmdif();

  run_controller #(.CNT_W(CNT_W), .STOP_OP(4'hF)) dut (
    .clk_i         (clk),
    .clr_i         (clr),
    .cmd_if        (cmdif),
    .pc_i          (pc),
    .fetch_i       (fetch),
    .opcode_i      (ir),
    .cpu_en_o      (cpu_en),
    .halted_o      (halted),
    .bp_hit_o      (bp_hit),
    .stopped_o     (stopped),
    .instr_count_o (count)
  );

  always #5 clk = ~clk;

  // Stand-in for the CPU sequencer: fetch loads IR, execute advances PC.
  always @(posedge clk) begin
    if (clr) begin
      fetch <= 1'b1;
      pc    <= 8'h00;
      ir    <= 4'h0;
    end else if (cpu_en) begin
      if (fetch) begin
        ir    <= prog[pc];
        fetch <= 1'b0;
      end else begin
        pc    <= pc + 8'd1;
        fetch <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "running", "finishing one instruction" and "stopped" flags; none set means halted.
  bit         mv = 1'b0;
  bit         m_run, m_fin, m_stop, m_bpen, m_skip, m_hit;
  logic [7:0] m_bpa;
  int         m_cnt;

  always @(negedge clk) begin
    bit match, en, rdy, ret, fire, idle;
    idle  = !(m_run || m_fin || m_stop);
    match = m_bpen && fetch && (pc == m_bpa) && !m_skip;
    en    = (m_run && !match) || m_fin;
    rdy   = !m_fin;
    ret   = en && !fetch;
    fire  = cmdif.cmd_vld && rdy;
    if (mv) begin
      chk("model_cpu_en", cpu_en, en);
      chk("model_cmd_rdy", cmdif.cmd_rdy, rdy);
      chk("model_halted", halted, idle);
      chk("model_stopped", stopped, m_stop);
      chk("model_bp_hit", bp_hit, m_hit);
      chk("model_count", count, m_cnt);
    end
    if (clr) begin
      {m_run, m_fin, m_stop, m_bpen, m_skip, m_hit} = '0;
      m_bpa = 8'h00;
      m_cnt = 0;
      mv    = 1'b1;
    end else if (mv) begin
      if (fire && cmdif.cmd_dat == C_CLRCNT) m_cnt = 0;
      else if (ret && m_cnt < CNT_MAX)      m_cnt = m_cnt + 1;
      if (fire && cmdif.cmd_dat == C_SETBP) begin m_bpa = cmdif.arg_dat; m_bpen = 1'b1; end
      if (fire && cmdif.cmd_dat == C_CLRBP) m_bpen = 1'b0;
      if (ret) m_skip = 1'b0;
      if (idle) begin
        if (fire && cmdif.cmd_dat == C_RUN)  begin m_run = 1'b1; m_hit = 1'b0; m_skip = 1'b1; end
        if (fire && cmdif.cmd_dat == C_STEP) begin m_fin = 1'b1; m_hit = 1'b0; end
      end else if (m_run) begin
        if (ret && ir == 4'hF) begin m_run = 1'b0; m_stop = 1'b1; end
        else if (match) begin m_run = 1'b0; m_hit = 1'b1; end
        else if (fire && cmdif.cmd_dat == C_HALT) begin m_run = 1'b0; m_fin = !ret; end
      end else if (m_fin && ret) begin
        m_fin = 1'b0;
        if (ir == 4'hF) m_stop = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] a);
    int n = 0;
    cmdif.cmd_vld = 1'b1;
    cmdif.cmd_dat = c;
    cmdif.arg_dat = a;
    @(negedge clk);
    while (!cmdif.cmd_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept_timeout", (n < 50), 1);
    @(posedge clk);
    #1;
    cmdif.cmd_vld = 1'b0;
  endtask

  task automatic wait_halt(input int limit);
    int n = 0;
    while (!halted && n < limit) begin
      tick(1);
      n++;
    end
    chk("wait_halt_timeout", halted, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    cmdif.cmd_vld = 1'b0;
    cmdif.cmd_dat = 3'd0;
    cmdif.arg_dat = 8'h00;
    for (int i = 0; i < 256; i++) prog[i] = 4'h0;
    clr = 1'b1;
    tick(2);
    clr = 1'b0;

    chk("rst_halted", halted, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_stopped", stopped, 0);
    chk("rst_cmd_rdy", cmdif.cmd_rdy, 1);
    chk("rst_count", count, 0);
    chk("rst_bp_hit", bp_hit, 0);

    // Three ADDs then STOP: eight enabled cycles, four retires.
    prog[3] = 4'hF;
    send(C_RUN, 8'h00);
    chk("t1_cpu_en", cpu_en, 1);
    tick(7);
    chk("t1_count_7", count, 3);
    chk("t1_stopped_7", stopped, 0);
    tick(1);
    chk("t1_count", count, 4);
    chk("t1_stopped", stopped, 1);
    chk("t1_cpu_en_off", cpu_en, 0);
    send(C_RUN, 8'h00);
    tick(2);
    chk("t1_run_ignored", stopped, 1);
    chk("t1_run_ignored_en", cpu_en, 0);
    chk("t1_count_hold", count, 4);

    // Single steps.
    prog[3] = 4'h0;
    do_clr();
    for (int i = 1; i <= 3; i++) begin
      send(C_STEP, 8'h00);
      chk("t2_rdy_low_a", cmdif.cmd_rdy, 0);
      tick(1);
      chk("t2_rdy_low_b", cmdif.cmd_rdy, 0);
      chk("t2_not_halted", halted, 0);
      tick(1);
      chk("t2_halted", halted, 1);
      chk("t2_count", count, i);
      chk("t2_rdy_back", cmdif.cmd_rdy, 1);
    end

    // Breakpoint at 0x05, then resume through it.
    do_clr();
    send(C_SETBP, 8'h05);
    send(C_RUN, 8'h00);
    wait_halt(60);
    chk("t3_fetch", fetch, 1);
    chk("t3_pc", pc, 8'h05);
    chk("t3_bp_hit", bp_hit, 1);
    chk("t3_count", count, 5);
    send(C_RUN, 8'h00);
    chk("t3_bp_hit_clr", bp_hit, 0);
    tick(4);
    chk("t3_resumed", halted, 0);
    chk("t3_count_after", count, 7);
    chk("t3_pc_after", pc, 8'h07);

    // HALT in fetch phase drains one execute cycle.
    send(C_HALT, 8'h00);
    chk("t4_drain_rdy", cmdif.cmd_rdy, 0);
    chk("t4_drain_en", cpu_en, 1);
    chk("t4_drain_not_halted", halted, 0);
    tick(1);
    chk("t4_halted", halted, 1);
    chk("t4_fetch", fetch, 1);
    chk("t4_count", count, 8);
    chk("t4_cpu_en", cpu_en, 0);

    // Saturation, then CLRCNT landing on a retire cycle.
    do_clr();
    send(C_RUN, 8'h00);
    tick(40);
    chk("t5_saturated", count, 4'hF);
    if (fetch) tick(1);
    send(C_CLRCNT, 8'h00);
    chk("t5_clrcnt", count, 0);
    tick(2);
    chk("t5_count_resumes", count, 1);

    // CLR mid-STEP.
    do_clr();
    send(C_SETBP, 8'h03);
    send(C_STEP, 8'h00);
    tick(1);
    send(C_STEP, 8'h00);
    tick(1);
    chk("t6_mid_step", fetch, 0);
    do_clr();
    chk("t6s_halted", halted, 1);
    chk("t6s_cpu_en", cpu_en, 0);
    chk("t6s_count", count, 0);
    chk("t6s_bp_hit", bp_hit, 0);

    // CLR in DRAIN, then confirm the breakpoint was disarmed.
    send(C_SETBP, 8'h03);
    send(C_RUN, 8'h00);
    tick(2);
    send(C_HALT, 8'h00);
    chk("t6d_in_drain", cmdif.cmd_rdy, 0);
    do_clr();
    chk("t6d_halted", halted, 1);
    chk("t6d_cpu_en", cpu_en, 0);
    chk("t6d_count", count, 0);
    send(C_RUN, 8'h00);
    tick(12);
    chk("t6d_bp_disarmed", halted, 0);
    chk("t6d_count_run", count, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
